ser_to_par16: RTL and testbench

SER_TO_PAR16 -- requirements
Module: ser_to_par16

---
 rtl/ser_to_par16_if.sv | 23 ++
 rtl/ser_to_par16.sv | 116 +++++++++++
 tb/tb_ser_to_par16.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ser_to_par16_if.sv
// Bundles the frame-sync/serial-input side and the word/status outputs of ser_to_par16.
// master: the serial source, which drives start/din/din_valid and observes the results.
// slave: the converter itself.
interface ser_to_par16_if;
   logic        start;
   logic        din;
   logic        din_valid;
   logic [15:0] x;
   logic        word_valid;
   logic        busy;
   logic [3:0]  bit_cnt;
   logic        frame_err;

   modport master (
      output start, din, din_valid,
      input  x, word_valid, busy, bit_cnt, frame_err
   );

   modport slave (
      input  start, din, din_valid,
      output x, word_valid, busy, bit_cnt, frame_err
   );
endinterface

// File: rtl/ser_to_par16.sv
// ser_to_par16: collects 16 serial bits per frame (sync on start) into word x for a pattern detector.
// Latency: x and word_valid update on the same edge that samples the 16th bit.
// Backpressure: none; din_valid=0 stalls collection. Macro SER_TO_PAR16_SLIDE_EN adds a sliding-window mode.
module ser_to_par16 #(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic          clk,
   input  logic          rst,
   ser_to_par16_if.slave bus
);

`ifdef SER_TO_PAR16_SLIDE_EN
   typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_SLIDE} state_t;
`else
   typedef enum logic {S_IDLE, S_COLLECT} state_t;
`endif

   state_t      r_state, w_state_nxt;
   logic [15:0] r_sr, w_sr_nxt;
   logic [3:0]  r_cnt, w_cnt_nxt;
   logic [15:0] r_x, w_x_nxt;
   logic        r_wv, w_wv_nxt;
   logic        r_fe, w_fe_nxt;

   logic [15:0] w_shift;    // shift register with din appended in frame order
   logic [15:0] w_first;    // shift register holding only din as bit 0 of a new frame

   assign w_shift = MSB_FIRST ? {r_sr[14:0], bus.din} : {bus.din, r_sr[15:1]};
   assign w_first = MSB_FIRST ? {15'd0, bus.din}      : {bus.din, 15'd0};

   // State register and all registered outputs; reset clears everything at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_sr    <= 16'h0000;
         r_cnt   <= 4'd0;
         r_x     <= 16'h0000;
         r_wv    <= 1'b0;
         r_fe    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_sr    <= w_sr_nxt;
         r_cnt   <= w_cnt_nxt;
         r_x     <= w_x_nxt;
         r_wv    <= w_wv_nxt;
         r_fe    <= w_fe_nxt;
      end
   end

   // Next-state and datapath: completion of the 16th bit outranks a coincident start.
   always_comb begin
      w_state_nxt = r_state;
      w_sr_nxt    = r_sr;
      w_cnt_nxt   = r_cnt;
      w_x_nxt     = r_x;
      w_wv_nxt    = 1'b0;
      w_fe_nxt    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.start) begin
               w_state_nxt = S_COLLECT;
               w_sr_nxt    = bus.din_valid ? w_first : 16'h0000;
               w_cnt_nxt   = {3'd0, bus.din_valid};
            end
         end
         S_COLLECT: begin
            if (bus.din_valid && (r_cnt == 4'd15)) begin
               w_x_nxt   = w_shift;
               w_wv_nxt  = 1'b1;
               w_sr_nxt  = w_shift;
               w_cnt_nxt = 4'd0;
               if (bus.start) begin
                  w_state_nxt = S_COLLECT;
               end else begin
`ifdef SER_TO_PAR16_SLIDE_EN
                  w_state_nxt = S_SLIDE;
`else
                  w_state_nxt = S_IDLE;
`endif
               end
            end else if (bus.start) begin
               // Abort of a partial frame: drop it and resync on this start.
               w_fe_nxt  = (r_cnt != 4'd0);
               w_sr_nxt  = bus.din_valid ? w_first : 16'h0000;
               w_cnt_nxt = {3'd0, bus.din_valid};
            end else if (bus.din_valid) begin
               w_sr_nxt  = w_shift;
               w_cnt_nxt = r_cnt + 4'd1;
            end
         end
`ifdef SER_TO_PAR16_SLIDE_EN
         S_SLIDE: begin
            if (bus.start) begin
               w_state_nxt = S_COLLECT;
               w_sr_nxt    = bus.din_valid ? w_first : 16'h0000;
               w_cnt_nxt   = {3'd0, bus.din_valid};
            end else if (bus.din_valid) begin
               w_sr_nxt = w_shift;
               w_x_nxt  = w_shift;
               w_wv_nxt = 1'b1;
            end
         end
`endif
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign bus.x          = r_x;
   assign bus.word_valid = r_wv;
   assign bus.frame_err  = r_fe;
   assign bus.bit_cnt    = r_cnt;
   assign bus.busy       = (r_state == S_COLLECT) && (r_cnt != 4'd0);

endmodule

// File: tb/tb_ser_to_par16.sv
// Bench for ser_to_par16: two instances (MSB_FIRST=1 and 0) share one input stream.
// A queue-based frame model predicts every output; a compare process checks each cycle,
// and directed sequences pin the model with hand-computed words.
module tb_ser_to_par16;

`ifdef SER_TO_PAR16_SLIDE_EN
   localparam bit SLIDE = 1'b1;
`else
   localparam bit SLIDE = 1'b0;
`endif

   logic clk;
   logic rst;
   logic start, din, din_valid;
   logic chk_en;

   int checks = 0;
   int errors = 0;

   ser_to_par16_if if1 ();
   ser_to_par16_if if0 ();

   assign if1.start = start;
   assign if1.din = din;
   assign if1.din_valid = din_valid;
   assign if0.start = start;
   assign if0.din = din;
   assign if0.din_valid = din_valid;

   ser_to_par16 #(.MSB_FIRST(1'b1)) dut_msb (.clk(clk), .rst(rst), .bus(if1));
   ser_to_par16 #(.MSB_FIRST(1'b0)) dut_lsb (.clk(clk), .rst(rst), .bus(if0));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   bit          m_inf;     // a frame is being collected
   bit          m_sl;      // sliding-window phase
   bit          m_bits[$]; // bits of current frame, oldest first
   bit          m_hist[$]; // latest 16 accepted bits, oldest first
   logic [15:0] m_x1, m_x0;
   bit          m_wv, m_fe;

   function automatic logic [15:0] word_of(input bit q[$], input bit msb);
      logic [15:0] w;
      w = '0;
      for (int k = 0; k < q.size() && k < 16; k++) begin
         if (msb) w[15-k] = q[k];
         else     w[k]    = q[k];
      end
      return w;
   endfunction

   task automatic new_frame(input bit d, input bit v);
      m_bits.delete();
      if (v) m_bits.push_back(d);
   endtask

   task automatic model_step(input bit s, input bit d, input bit v);
      m_wv = 1'b0;
      m_fe = 1'b0;
      if (m_inf) begin
         if (v && m_bits.size() == 15) begin
            m_bits.push_back(d);
            m_x1 = word_of(m_bits, 1'b1);
            m_x0 = word_of(m_bits, 1'b0);
            m_wv = 1'b1;
            m_hist = m_bits;
            m_bits.delete();
            if (!s) begin
               m_inf = 1'b0;
               m_sl  = SLIDE;
            end
         end else if (s) begin
            if (m_bits.size() > 0) m_fe = 1'b1;
            new_frame(d, v);
         end else if (v) begin
            m_bits.push_back(d);
         end
      end else if (s) begin
         m_sl  = 1'b0;
         m_inf = 1'b1;
         new_frame(d, v);
      end else if (m_sl && v) begin
         m_hist.push_back(d);
         void'(m_hist.pop_front());
         m_x1 = word_of(m_hist, 1'b1);
         m_x0 = word_of(m_hist, 1'b0);
         m_wv = 1'b1;
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_inf = 1'b0;
         m_sl  = 1'b0;
         m_bits.delete();
         m_hist.delete();
         m_x1 = 16'h0000;
         m_x0 = 16'h0000;
         m_wv = 1'b0;
         m_fe = 1'b0;
      end else begin
         model_step(start, din, din_valid);
      end
   end

   // ---------------- checking ----------------
   task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en && !rst) begin
         cmp("x_msb",          32'(if1.x),          32'(m_x1));
         cmp("x_lsb",          32'(if0.x),          32'(m_x0));
         cmp("word_valid_msb", 32'(if1.word_valid), 32'(m_wv));
         cmp("word_valid_lsb", 32'(if0.word_valid), 32'(m_wv));
         cmp("frame_err_msb",  32'(if1.frame_err),  32'(m_fe));
         cmp("frame_err_lsb",  32'(if0.frame_err),  32'(m_fe));
         cmp("bit_cnt",        32'(if1.bit_cnt),    m_inf ? 32'(m_bits.size()) : 32'd0);
         cmp("busy",           32'(if1.busy),       32'(m_inf && m_bits.size() > 0));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input bit s, input bit d, input bit v);
      @(negedge clk);
      start = s;
      din = d;
      din_valid = v;
   endtask

   // Stream w MSB-first (frame bit k = w[15-k]); start rides on bit 0.
   task automatic send_word(input logic [15:0] w, input int maxgap);
      for (int k = 0; k < 16; k++) begin
         repeat ($urandom_range(0, maxgap)) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
         step(k == 0, w[15-k], 1'b1);
      end
   endtask

   task automatic check_zero(input string tag);
      cmp({tag, "_x"},    32'(if1.x),          32'd0);
      cmp({tag, "_wv"},   32'(if1.word_valid), 32'd0);
      cmp({tag, "_busy"}, 32'(if1.busy),       32'd0);
      cmp({tag, "_cnt"},  32'(if1.bit_cnt),    32'd0);
      cmp({tag, "_fe"},   32'(if1.frame_err),  32'd0);
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      din = 1'b0;
      din_valid = 1'b0;
      chk_en = 1'b0;
      #12;
      check_zero("reset");
      @(negedge clk);
      #2 rst = 1'b0;
      chk_en = 1'b1;

      // Continuous frame 1010_1100_0011_0101 (palindrome, so both orders give AC35).
      send_word(16'hAC35, 0);
      step(1'b0, 1'b0, 1'b0);
      cmp("basic_wv",   32'(if1.word_valid), 32'd1);
      cmp("basic_x1",   32'(if1.x),          32'hAC35);
      cmp("basic_x0",   32'(if0.x),          32'hAC35);
      cmp("basic_cnt",  32'(if1.bit_cnt),    32'd0);
      cmp("basic_busy", 32'(if1.busy),       32'd0);
      step(1'b0, 1'b0, 1'b0);
      cmp("basic_wv_off", 32'(if1.word_valid), 32'd0);
      cmp("basic_x_hold", 32'(if1.x),          32'hAC35);

      // Abort: start, 7 bits, restart carrying bit 0, then 15 more ones.
      step(1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 7; k++) step(1'b0, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1);
      for (int k = 1; k < 16; k++) begin
         step(1'b0, 1'b1, 1'b1);
         if (k == 1) begin
            cmp("abort_fe",   32'(if1.frame_err), 32'd1);
            cmp("abort_cnt",  32'(if1.bit_cnt),   32'd1);
            cmp("abort_hold", 32'(if1.x),         32'hAC35);
         end
         if (k == 2) cmp("abort_fe_off", 32'(if1.frame_err), 32'd0);
      end
      step(1'b0, 1'b0, 1'b0);
      cmp("abort_x", 32'(if1.x), 32'hFFFF);

      // Gapped stream must give the same word.
      send_word(16'hAC35, 3);
      step(1'b0, 1'b0, 1'b0);
      cmp("gap_x1", 32'(if1.x), 32'hAC35);
      cmp("gap_x0", 32'(if0.x), 32'hAC35);

      // start coinciding with the 16th bit: word completes, no frame_err.
      for (int k = 0; k < 15; k++) step(k == 0, 1'(k % 2), 1'b1);
      step(1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      cmp("coinc_wv",  32'(if1.word_valid), 32'd1);
      cmp("coinc_fe",  32'(if1.frame_err),  32'd0);
      cmp("coinc_cnt", 32'(if1.bit_cnt),    32'd0);
      cmp("coinc_x1",  32'(if1.x),          32'h5555);

      // Reset after 9 bits of a frame, then a clean 0x1234 frame.
      for (int k = 0; k < 9; k++) step(k == 0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b0);
      cmp("pre_rst_busy", 32'(if1.busy), 32'd1);
      #3 rst = 1'b1;
      #1 check_zero("midrst");
      @(negedge clk);
      #2 rst = 1'b0;
      send_word(16'h1234, 1);
      step(1'b0, 1'b0, 1'b0);
      cmp("post_rst_x1", 32'(if1.x), 32'h1234);
      cmp("post_rst_x0", 32'(if0.x), 32'h2C48);

`ifdef SER_TO_PAR16_SLIDE_EN
      send_word(16'h8000, 0);
      step(1'b0, 1'b1, 1'b1);
      cmp("slide_wv1", 32'(if1.word_valid), 32'd1);
      cmp("slide_x1a", 32'(if1.x),          32'h8000);
      cmp("slide_x0a", 32'(if0.x),          32'h0001);
      step(1'b0, 1'b0, 1'b0);
      cmp("slide_wv2", 32'(if1.word_valid), 32'd1);
      cmp("slide_x1b", 32'(if1.x),          32'h0001);
      cmp("slide_x0b", 32'(if0.x),          32'h8000);
      step(1'b0, 1'b0, 1'b0);
      cmp("slide_wv3", 32'(if1.word_valid), 32'd0);
`endif

      // Random traffic with occasional asynchronous resets.
      for (int i = 0; i < 1500; i++) begin
         step($urandom_range(0, 24) == 0, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
         if ($urandom_range(0, 299) == 0) begin
            #3 rst = 1'b1;
            #1 check_zero("rndrst");
            @(negedge clk);
            #2 rst = 1'b0;
         end
      end
      step(1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      chk_en = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
